// File: rtl/eater_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// eater_ctrl_pkg
// Shared definitions for the control stage of the 8-bit computer:
//   - control-word bit positions and one-hot masks, {HLT..FI} MSB first
//   - opcode constants
//   - fetch row constants common to every instruction
//   - default widths and the default number of T-states per instruction
// -----------------------------------------------------------------------------
package eater_ctrl_pkg;

  localparam int T_STATES_DEFAULT = 5;
  localparam int CW_WIDTH_DEFAULT = 16;
  localparam int OP_WIDTH_DEFAULT = 4;
  localparam int TS_WIDTH         = 3;

  typedef logic [CW_WIDTH_DEFAULT-1:0] cw_t;

  // Control-word bit positions.
  localparam int CW_HLT = 15;
  localparam int CW_MI  = 14;
  localparam int CW_RI  = 13;
  localparam int CW_RO  = 12;
  localparam int CW_IO  = 11;
  localparam int CW_II  = 10;
  localparam int CW_AI  = 9;
  localparam int CW_AO  = 8;
  localparam int CW_EO  = 7;
  localparam int CW_SU  = 6;
  localparam int CW_BI  = 5;
  localparam int CW_OI  = 4;
  localparam int CW_CE  = 3;
  localparam int CW_CO  = 2;
  localparam int CW_J   = 1;
  localparam int CW_FI  = 0;

  // Flag bit positions inside the {carry, zero} flags register.
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  function automatic cw_t cw_bit(input int unsigned idx);
    return cw_t'(1) << idx;
  endfunction

  localparam cw_t M_HLT = cw_bit(CW_HLT);
  localparam cw_t M_MI  = cw_bit(CW_MI);
  localparam cw_t M_RI  = cw_bit(CW_RI);
  localparam cw_t M_RO  = cw_bit(CW_RO);
  localparam cw_t M_IO  = cw_bit(CW_IO);
  localparam cw_t M_II  = cw_bit(CW_II);
  localparam cw_t M_AI  = cw_bit(CW_AI);
  localparam cw_t M_AO  = cw_bit(CW_AO);
  localparam cw_t M_EO  = cw_bit(CW_EO);
  localparam cw_t M_SU  = cw_bit(CW_SU);
  localparam cw_t M_BI  = cw_bit(CW_BI);
  localparam cw_t M_OI  = cw_bit(CW_OI);
  localparam cw_t M_CE  = cw_bit(CW_CE);
  localparam cw_t M_CO  = cw_bit(CW_CO);
  localparam cw_t M_J   = cw_bit(CW_J);
  localparam cw_t M_FI  = cw_bit(CW_FI);

  // Fetch rows shared by all opcodes.
  localparam cw_t ROW_FETCH_T0 = M_CO | M_MI;
  localparam cw_t ROW_FETCH_T1 = M_RO | M_II | M_CE;

  typedef enum logic [OP_WIDTH_DEFAULT-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

endpackage

// File: rtl/microcode_rom.sv
// -----------------------------------------------------------------------------
// microcode_rom
// Purely combinational microcode lookup: (opcode, T-state, flags) -> row.
// Ports:
//   opcode_i   in  instruction register upper nibble
//   t_state_i  in  micro-step to look up (values past the last step give 0)
//   flags_i    in  {carry, zero}, used by the conditional jumps
//   row_o      out control word row for that micro-step
// -----------------------------------------------------------------------------
module microcode_rom
  import eater_ctrl_pkg::*;
(
  input  logic [OP_WIDTH_DEFAULT-1:0] opcode_i,
  input  logic [TS_WIDTH-1:0]         t_state_i,
  input  logic [1:0]                  flags_i,
  output cw_t                         row_o
);

  // NOTE: every output of an always_comb block gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    row_o = '0;
    if (t_state_i == 3'd0) begin
      row_o = ROW_FETCH_T0;
    end else if (t_state_i == 3'd1) begin
      row_o = ROW_FETCH_T1;
    end else begin
      case (opcode_i)
        OP_LDA: begin
          if (t_state_i == 3'd2)      row_o = M_IO | M_MI;
          else if (t_state_i == 3'd3) row_o = M_RO | M_AI;
        end
        OP_ADD: begin
          if (t_state_i == 3'd2)      row_o = M_IO | M_MI;
          else if (t_state_i == 3'd3) row_o = M_RO | M_BI;
          else if (t_state_i == 3'd4) row_o = M_EO | M_AI | M_FI;
        end
        OP_SUB: begin
          if (t_state_i == 3'd2)      row_o = M_IO | M_MI;
          else if (t_state_i == 3'd3) row_o = M_RO | M_BI;
          else if (t_state_i == 3'd4) row_o = M_EO | M_AI | M_SU | M_FI;
        end
        OP_STA: begin
          if (t_state_i == 3'd2)      row_o = M_IO | M_MI;
          else if (t_state_i == 3'd3) row_o = M_AO | M_RI;
        end
        OP_LDI: if (t_state_i == 3'd2) row_o = M_IO | M_AI;
        OP_JMP: if (t_state_i == 3'd2) row_o = M_IO | M_J;
        // Conditional jumps collapse to an empty T2 when not taken.
        OP_JC:  if (t_state_i == 3'd2 && flags_i[FLAG_C]) row_o = M_IO | M_J;
        OP_JZ:  if (t_state_i == 3'd2 && flags_i[FLAG_Z]) row_o = M_IO | M_J;
        OP_OUT: if (t_state_i == 3'd2) row_o = M_AO | M_OI;
        OP_HLT: if (t_state_i == 3'd2) row_o = M_HLT;
        default: row_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
// Control stage of the 8-bit computer. Owns the T-state counter, the
// {carry, zero} flags register and the sticky halt bit, and decodes the
// current opcode/T-state/flags into the control word.
// Ports:
//   system_clock  in  system clock, all state on the rising edge
//   system_reset  in  synchronous active-high reset
//   step_en       in  one-cycle pulse per machine step
//   opcode        in  instruction register upper nibble
//   alu_carry     in  ALU carry-out, captured on steps whose row has FI
//   alu_zero      in  ALU zero flag, captured on steps whose row has FI
//   control_word  out {HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J,FI}
//   t_state       out current micro-step
//   flags         out registered {carry, zero}
//   halted        out sticky halt indicator
// -----------------------------------------------------------------------------
module microcode_sequencer
  import eater_ctrl_pkg::*;
#(
  parameter int T_STATES = T_STATES_DEFAULT,
  parameter int CW_WIDTH = CW_WIDTH_DEFAULT,
  parameter int OP_WIDTH = OP_WIDTH_DEFAULT
) (
  input  logic                system_clock,
  input  logic                system_reset,
  input  logic                step_en,
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic                alu_carry,
  input  logic                alu_zero,
  output logic [CW_WIDTH-1:0] control_word,
  output logic [2:0]          t_state,
  output logic [1:0]          flags,
  output logic                halted
);

  localparam logic [TS_WIDTH-1:0] T_LAST = TS_WIDTH'(T_STATES - 1);

  logic [TS_WIDTH-1:0] t_state_q, t_state_d;
  logic [1:0]          flags_q, flags_d;
  logic                halted_q, halted_d;
  logic [TS_WIDTH-1:0] t_next;
  cw_t                 cur_row;
  cw_t                 next_row;

  assign t_next = t_state_q + 3'd1;

  microcode_rom u_rom_cur (
    .opcode_i  (opcode),
    .t_state_i (t_state_q),
    .flags_i   (flags_q),
    .row_o     (cur_row)
  );

  // Looks one step ahead so an instruction whose remaining rows are empty
  // returns to fetch instead of idling through blank T-states.
  microcode_rom u_rom_next (
    .opcode_i  (opcode),
    .t_state_i (t_next),
    .flags_i   (flags_q),
    .row_o     (next_row)
  );

  always_comb begin
    t_state_d = t_state_q;
    flags_d   = flags_q;
    halted_d  = halted_q;
    if (step_en && !halted_q) begin
      if (cur_row[CW_FI]) begin
        flags_d = {alu_carry, alu_zero};
      end
      if (cur_row[CW_HLT]) begin
        // The counter parks on the HLT row; only reset releases it.
        halted_d = 1'b1;
      end else if (t_state_q == T_LAST ||
                   (t_state_q >= 3'd2 && next_row == '0)) begin
        t_state_d = '0;
      end else begin
        t_state_d = t_next;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      t_state_q <= '0;
      flags_q   <= '0;
      halted_q  <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      flags_q   <= flags_d;
      halted_q  <= halted_d;
    end
  end

  assign control_word = halted_q ? '0 : cur_row;
  assign t_state      = t_state_q;
  assign flags        = flags_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_microcode_sequencer
// Scoreboard bench: the driver applies one cycle of stimulus, predicts the
// outputs visible during that cycle from an instruction-level model and
// queues them tagged with the sampling time; a monitor on the falling edge
// pops and compares.
// -----------------------------------------------------------------------------
module tb_microcode_sequencer;

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000,
                          RO  = 16'h1000, IO = 16'h0800, II = 16'h0400,
                          AI  = 16'h0200, AO = 16'h0100, EO = 16'h0080,
                          SU  = 16'h0040, BI = 16'h0020, OI = 16'h0010,
                          CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002,
                          FI  = 16'h0001;

  logic        system_clock;
  logic        system_reset;
  logic        step_en;
  logic [3:0]  opcode;
  logic        alu_carry;
  logic        alu_zero;
  logic [15:0] control_word;
  logic [2:0]  t_state;
  logic [1:0]  flags;
  logic        halted;

  microcode_sequencer dut (
    .system_clock (system_clock),
    .system_reset (system_reset),
    .step_en      (step_en),
    .opcode       (opcode),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .control_word (control_word),
    .t_state      (t_state),
    .flags        (flags),
    .halted       (halted)
  );

  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  typedef struct {
    time         when;
    logic [2:0]  t;
    logic [1:0]  f;
    logic        h;
    logic [15:0] cw;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp_v);
    end
  endtask

  // ---------------- Instruction-level reference model ----------------
  // An instruction is the list of its non-empty micro-rows (at least three
  // steps long); the counter walks that list and returns to 0 at its end.
  int          m_t;
  bit          m_c, m_z, m_h;
  logic [15:0] m_prog[$];

  task automatic build_prog(input logic [3:0] op, input bit c, input bit z);
    m_prog = {CO | MI, RO | II | CE};
    case (op)
      4'h1: begin m_prog.push_back(IO | MI); m_prog.push_back(RO | AI); end
      4'h2: begin
        m_prog.push_back(IO | MI); m_prog.push_back(RO | BI);
        m_prog.push_back(EO | AI | FI);
      end
      4'h3: begin
        m_prog.push_back(IO | MI); m_prog.push_back(RO | BI);
        m_prog.push_back(EO | AI | SU | FI);
      end
      4'h4: begin m_prog.push_back(IO | MI); m_prog.push_back(AO | RI); end
      4'h5: m_prog.push_back(IO | AI);
      4'h6: m_prog.push_back(IO | J);
      4'h7: if (c) m_prog.push_back(IO | J);
      4'h8: if (z) m_prog.push_back(IO | J);
      4'hE: m_prog.push_back(AO | OI);
      4'hF: m_prog.push_back(HLT);
      default: ;
    endcase
    while (m_prog.size() < 3) m_prog.push_back(16'h0000);
  endtask

  // One clock of stimulus; called shortly after a rising edge.
  task automatic cycle(input bit r, input bit s, input logic [3:0] op,
                       input bit c, input bit z);
    exp_t        e;
    logic [15:0] cur;
    system_reset = r;
    step_en      = s;
    opcode       = op;
    alu_carry    = c;
    alu_zero     = z;
    build_prog(op, m_c, m_z);
    e.when = $time + 4;
    e.t    = 3'(m_t);
    e.f    = {m_c, m_z};
    e.h    = m_h;
    e.cw   = m_h ? 16'h0000 : m_prog[m_t];
    sb.push_back(e);
    if (r) begin
      m_t = 0; m_c = 0; m_z = 0; m_h = 0;
    end else if (s && !m_h) begin
      cur = m_prog[m_t];
      if ((cur & FI) != 0) begin m_c = c; m_z = z; end
      if ((cur & HLT) != 0) m_h = 1;
      else if (m_t + 1 >= m_prog.size()) m_t = 0;
      else m_t = m_t + 1;
    end
    @(posedge system_clock);
    #1;
  endtask

  task automatic steps(input int n, input logic [3:0] op);
    for (int i = 0; i < n; i++) cycle(0, 1, op, 0, 0);
  endtask

  // ---------------- Monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge system_clock);
      while (sb.size() != 0 && sb[0].when <= $time) begin
        e = sb.pop_front();
        check("sample_time", 32'($time), 32'(e.when));
        check("t_state", 32'(t_state), 32'(e.t));
        check("flags", 32'(flags), 32'(e.f));
        check("halted", 32'(halted), 32'(e.h));
        check("control_word", 32'(control_word), 32'(e.cw));
      end
    end
  end

  // ---------------- Stimulus ----------------
  initial begin
    logic [3:0] op_cur;
    bit         r, s;
    system_reset = 1'b1;
    step_en      = 1'b0;
    opcode       = 4'h0;
    alu_carry    = 1'b0;
    alu_zero     = 1'b0;
    m_t = 0; m_c = 0; m_z = 0; m_h = 0;
    @(posedge system_clock);
    #1;

    // Idle after reset: fetch T0 row, everything cleared.
    repeat (10) cycle(0, 0, 4'h0, 0, 0);

    // ADD with carry=1, zero=0 at T4.
    steps(4, 4'h2);
    cycle(0, 1, 4'h2, 1, 0);
    cycle(0, 0, 4'h2, 0, 0);

    // LDI terminates early after T2.
    steps(3, 4'h5);
    cycle(0, 0, 4'h5, 0, 0);

    // JZ not taken (zero flag clear), then SUB sets zero, JZ taken.
    steps(3, 4'h8);
    cycle(0, 0, 4'h8, 0, 0);
    steps(4, 4'h3);
    cycle(0, 1, 4'h3, 0, 1);
    steps(3, 4'h8);
    cycle(0, 0, 4'h8, 0, 0);

    // Reset together with a step at T3 of ADD: no flag capture.
    steps(3, 4'h2);
    cycle(1, 1, 4'h2, 1, 1);
    cycle(0, 0, 4'h2, 0, 0);

    // HLT: halts on the T2 step, further steps ignored, reset releases.
    steps(3, 4'hF);
    steps(5, 4'hF);
    cycle(0, 0, 4'hF, 0, 0);
    cycle(1, 0, 4'hF, 0, 0);
    cycle(0, 0, 4'h0, 0, 0);

    // Randomised run.
    op_cur = 4'h0;
    for (int i = 0; i < 2000; i++) begin
      if (m_h) r = ($urandom_range(0, 7) == 0);
      else     r = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 99) < 60);
      if (m_t == 0 && !m_h) begin
        op_cur = 4'($urandom_range(0, 15));
        if (op_cur == 4'hF && $urandom_range(0, 3) != 0) op_cur = 4'h2;
      end
      cycle(r, s, op_cur, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    cycle(0, 0, op_cur, 0, 0);
    @(negedge system_clock);
    #1;
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
